// File: rtl/dir_input_queue.sv
// dir_input_queue: debounced snake direction/pause controller with a direction queue
// Ports:
//   clk_25M     - sole clock
//   rst         - synchronous active-high reset
//   key_up/key_down/key_left/key_right/pause - raw asynchronous buttons
//   tick        - game-step strobe, pops one queued direction
//   key_stroke  - 100 while paused, else {0, dir_out}
//   dir_out     - applied direction (UP=00 DOWN=01 LEFT=10 RIGHT=11)
//   paused      - pause state
//   q_count     - queued direction count
//   drop        - one-cycle pulse per rejected direction press
module dir_input_queue #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int QUEUE_DEPTH     = 4
) (
    input  logic                           clk_25M,
    input  logic                           rst,
    input  logic                           key_up,
    input  logic                           key_down,
    input  logic                           key_left,
    input  logic                           key_right,
    input  logic                           pause,
    input  logic                           tick,
    output logic [2:0]                     key_stroke,
    output logic [1:0]                     dir_out,
    output logic                           paused,
    output logic [$clog2(QUEUE_DEPTH):0]   q_count,
    output logic                           drop
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [4:0]    w_raw, r_sync1, r_sync2, r_db, r_db_prev, w_press;
    logic [TW-1:0] r_cnt [5];
    logic [1:0]    r_mem [QUEUE_DEPTH];
    logic [PW-1:0] r_rptr, r_wptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_dir, r_last, w_cand, w_dir_nx;
    logic [2:0]    r_ks;
    logic          r_paused, r_drop, w_has, w_pop, w_push, w_paused_nx;

    // bit index doubles as the direction code for the four direction buttons
    assign w_raw   = {pause, key_right, key_left, key_down, key_up};
    assign w_press = r_db & ~r_db_prev;

    always_comb begin
        w_has       = |w_press[3:0];
        w_cand      = w_press[3] ? 2'd3 : w_press[2] ? 2'd2 : w_press[1] ? 2'd1 : 2'd0;
        w_pop       = tick & ~r_paused & (r_count != '0);
        // opposite directions differ only in bit 0
        w_push      = w_has & ~r_paused & (w_cand != r_last) & (w_cand != {r_last[1], ~r_last[0]})
                      & ((r_count != CW'(QUEUE_DEPTH)) | w_pop);
        w_paused_nx = r_paused ^ w_press[4];
        w_dir_nx    = w_pop ? r_mem[r_rptr] : r_dir;
    end

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == TW'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]  <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_25M) begin
        if (rst) begin
            r_rptr   <= '0;
            r_wptr   <= '0;
            r_count  <= '0;
            r_dir    <= 2'd3;
            r_last   <= 2'd3;
            r_paused <= 1'b0;
            r_drop   <= 1'b0;
            r_ks     <= 3'b011;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_cand;
                r_wptr        <= r_wptr + PW'(1);
                r_last        <= w_cand;
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
            r_dir    <= w_dir_nx;
            r_paused <= w_paused_nx;
            r_drop   <= w_has & ~w_push;
            r_ks     <= w_paused_nx ? 3'b100 : {1'b0, w_dir_nx};
        end
    end

    assign key_stroke = r_ks;
    assign dir_out    = r_dir;
    assign paused     = r_paused;
    assign q_count    = r_count;
    assign drop       = r_drop;
endmodule

// File: doc/dir_input_queue.md
# dir_input_queue

Parametrised direction input controller for the snake game, clocked at 25 MHz. It synchronises and debounces the five raw buttons (up, down, left, right, pause), turns debounced presses into single events, and queues direction changes so that quick multi-key turns made between game steps are not lost. It drops illegal turns: a reversal, or a repeat of the last accepted direction. Direction and pause state go to the game logic through the existing 3-bit `key_stroke` encoding (UP=000, DOWN=001, LEFT=010, RIGHT=011, PAUSE=100).

## Interface
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable synchronised samples needed to flip a debounced level. Must be ≥1.
- `QUEUE_DEPTH`, default 4: number of direction queue entries. Must be a power of 2 and ≥2.
- `clk_25M` input, 1 bit: the only clock.
- `rst` input, 1 bit: reset, **synchronous and active-high**.
- `key_up`, `key_down`, `key_left`, `key_right`, `pause` inputs, 1 bit each: raw, asynchronous buttons, active-high.
- `tick` input, 1 bit: one-cycle game-step strobe that pops one queued direction.
- `key_stroke` output, 3 bits: PAUSE (100) while paused, otherwise `{1'b0, dir_out}`.
- `dir_out` output, 2 bits: current applied direction.
- `paused` output, 1 bit: pause state.
- `q_count` output, clog2(QUEUE_DEPTH)+1 bits: number of queued entries.
- `drop` output, 1 bit: one-cycle pulse when a direction press is rejected.

## Operation
- **Synchronisers.** Each button has a 2-flop synchroniser, giving a synchronised level `s`.
- **Debounce.** Each button has a counter and a debounced level `db`.
  - If `s == db`, the counter clears.
  - Otherwise the counter increments. On the cycle the counter would reach DEBOUNCE_CYCLES, `db` takes the value of `s` and the counter clears.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES cycles has no effect.
- **Press event.** A press is `db & ~db_prev`, with `db_prev` registered. Releases generate nothing.
- **Pause press.** Toggles `paused`.
- **Direction press, same cycle.** If several direction presses occur in one cycle, priority is RIGHT > LEFT > DOWN > UP. Only the winner is considered.
- **Direction press, accept/reject.** The candidate is evaluated against `last_dir`, the most recently accepted direction (queued or applied).
  - Rejected, with `drop` pulsed, if `paused`=1.
  - Rejected if candidate == `last_dir`.
  - Rejected if the candidate is the opposite of `last_dir`: UP/DOWN and LEFT/RIGHT are opposites, i.e. they differ only in bit 0.
  - Rejected if the queue is full after accounting for a same-cycle pop.
  - Otherwise the candidate is written at the tail and `last_dir` is set to the candidate.
- **Pop.** When `tick`=1, `paused`=0 and `q_count`>0, the head moves into `dir_out` and `q_count` decrements. A `tick` with an empty queue, or while paused, changes nothing.
- **Decision state.** All decisions in a cycle use registered state from before the edge. A pause toggle therefore does not affect a `tick` or direction press in the same cycle.
- **Queue pointers.** Circular buffer. Read and write pointers are clog2(QUEUE_DEPTH) bits and wrap modulo QUEUE_DEPTH.
- **Simultaneous push and pop.** Both occur and `q_count` is unchanged. When full, a push is accepted if a pop happens in the same cycle.

## Timing
- **Reset values** (at the first edge with `rst`=1):
  - `dir_out`=11 (RIGHT), `last_dir`=11, `key_stroke`=011.
  - `paused`=0, `q_count`=0, `drop`=0, pointers=0.
  - Synchronisers, `db`, `db_prev` and counters all 0.
- **Reset mid-operation.** Queue contents are discarded.
- **Button held through reset.** Produces a press DEBOUNCE_CYCLES+2 edges after `rst` falls.
- **Press latency.** Count from the first edge sampling a raw button high, with the button held stable:
  - `s` is high after edge 2.
  - `db` is high after edge 2+DEBOUNCE_CYCLES.
  - The enqueue or `paused` toggle, and the `drop` pulse, become visible after edge 3+DEBOUNCE_CYCLES.
- **Pop latency.** `dir_out` and `key_stroke` update at the edge that samples `tick`, one cycle.
- **Output registration.** All outputs are registered. `drop` is high for exactly one cycle per rejected press.

## Test plan
All tests use DEBOUNCE_CYCLES=4 and QUEUE_DEPTH=4.
1. **Reset:** assert `rst` for 2 cycles → `key_stroke`=011, `dir_out`=11, `q_count`=0, `paused`=0, `drop`=0.
2. **Debounce:**
   - Pulse `key_up` for 3 cycles → `q_count` stays 0.
   - Hold `key_up` for 10 cycles → `q_count`=1 after edge 7.
   - Then `tick` → `dir_out`=00, `key_stroke`=000, `q_count`=0.
3. **Reject:** from reset, press `key_left` → `drop` pulses, `q_count`=0. Press `key_right` → `drop` pulses. Press `key_down` and `key_left` in the same cycle → LEFT wins and is dropped, DOWN is not queued.
4. **Queue full / wrap:**
   - Press UP, RIGHT, DOWN, LEFT in turn → `q_count`=4.
   - Press UP → `drop`.
   - 4 ticks → `dir_out` = 00, 11, 01, 10.
   - Repeat the sequence to exercise pointer wrap.
5. **Full with pop:** with `q_count`=4 and `last_dir`=LEFT, the UP enqueue and `tick` land on the same edge → no `drop`, `q_count` stays 4, the popped head is the oldest entry.
6. **Pause:**
   - Press `pause` → `key_stroke`=100.
   - `tick` with `q_count`=2 → unchanged.
   - Direction press → `drop`.
   - Press `pause` again → `key_stroke`={0, `dir_out`}, and the next `tick` pops.
